// File: rtl/pwr_pkg.sv
// rtl/pwr_pkg.sv - shared constants, weights and read FSM encoding for power counters
package pwr_pkg;

    localparam int CNT_W_DEF    = 16;
    localparam int WEIGHT_W_DEF = 4;

    // Relative switching cost per gate type, mirroring the gate-level power table
    localparam logic [WEIGHT_W_DEF-1:0] P_INV  = 4'd1;
    localparam logic [WEIGHT_W_DEF-1:0] P_AND2 = 4'd2;
    localparam logic [WEIGHT_W_DEF-1:0] P_AND3 = 4'd3;
    localparam logic [WEIGHT_W_DEF-1:0] P_AND4 = 4'd4;
    localparam logic [WEIGHT_W_DEF-1:0] P_AND5 = 4'd5;
    localparam logic [WEIGHT_W_DEF-1:0] P_OR2  = 4'd2;
    localparam logic [WEIGHT_W_DEF-1:0] P_OR3  = 4'd3;
    localparam logic [WEIGHT_W_DEF-1:0] P_OR4  = 4'd4;
    localparam logic [WEIGHT_W_DEF-1:0] P_OR5  = 4'd5;
    localparam logic [WEIGHT_W_DEF-1:0] P_XOR2 = 4'd4;
    localparam logic [WEIGHT_W_DEF-1:0] P_XOR3 = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_RESP  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/pwr_cntr_reader_if.sv
// rtl/pwr_cntr_reader_if.sv - counter read request/response handshake bundle
interface pwr_cntr_reader_if #(
    parameter int N_NETS = 8,
    parameter int CNT_W  = 16
);
    localparam int IDX_W = (N_NETS > 1) ? $clog2(N_NETS) : 1;

    logic             rd_req;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_valid;
    logic [CNT_W-1:0] rd_data;
    logic             rd_ovf;
    logic             rd_ack;
    logic             busy;

    modport master (
        output rd_req, rd_idx, rd_ack,
        input  rd_valid, rd_data, rd_ovf, busy
    );

    modport slave (
        input  rd_req, rd_idx, rd_ack,
        output rd_valid, rd_data, rd_ovf, busy
    );

endinterface

// File: rtl/pwr_sat_acc.sv
// rtl/pwr_sat_acc.sv - one saturating weighted event counter with sticky overflow
module pwr_sat_acc #(
    parameter int CNT_W    = 16,
    parameter int WEIGHT_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc,
    input  logic                clr,
    input  logic [WEIGHT_W-1:0] weight,
    output logic [CNT_W-1:0]    cnt,
    output logic                ovf
);
    localparam int SUM_W = CNT_W + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [SUM_W-1:0] base, sum;

    // A clear coinciding with an increment restarts from zero so the new event survives
    always_comb begin
        base  = clr ? '0 : {1'b0, cnt_q};
        sum   = base + SUM_W'(weight);
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end
        if (inc) begin
            if (sum[CNT_W]) begin
                cnt_d = '1;
                ovf_d = 1'b1;
            end else begin
                cnt_d = sum[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/pwr_cntr_reader.sv
// rtl/pwr_cntr_reader.sv - rising-edge weighted power counters with handshake readback
module pwr_cntr_reader
    import pwr_pkg::*;
#(
    parameter int N_NETS    = 8,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int WEIGHT_W  = WEIGHT_W_DEF,
    parameter int CLR_ON_RD = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [N_NETS-1:0]          nets,
    input  logic [N_NETS*WEIGHT_W-1:0] weights,
    pwr_cntr_reader_if.slave           rd_if
);
    localparam int IDX_W = (N_NETS > 1) ? $clog2(N_NETS) : 1;

    logic [N_NETS-1:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [2:0]        prime_q, prime_d;
    logic [N_NETS-1:0] edge_vec, inc_vec, clr_vec;
    logic [N_NETS-1:0][CNT_W-1:0] cnt_all;
    logic [N_NETS-1:0] ovf_all;

    rd_state_e         state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  rd_data_q;
    logic              rd_ovf_q, rd_valid_q, busy_q;
    logic              idx_ok, fetch_clr;

    // Prime only qualifies edges once s3 has caught up, so a net high through reset never counts
    always_comb begin
        s1_d    = nets;
        s2_d    = s1_q;
        s3_d    = s2_q;
        prime_d = {prime_q[1:0], 1'b1};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            prime_q <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            s3_q    <= s3_d;
            prime_q <= prime_d;
        end
    end

    assign edge_vec  = s2_q & ~s3_q & {N_NETS{prime_q[2]}};
    assign inc_vec   = edge_vec & {N_NETS{enable}};
    assign idx_ok    = int'(idx_q) < N_NETS;
    assign fetch_clr = (state_q == ST_FETCH) && (CLR_ON_RD != 0) && idx_ok;

    for (genvar i = 0; i < N_NETS; i++) begin : g_acc
        assign clr_vec[i] = fetch_clr && (idx_q == IDX_W'(i));

        pwr_sat_acc #(
            .CNT_W    (CNT_W),
            .WEIGHT_W (WEIGHT_W)
        ) u_acc (
            .clk    (clk),
            .reset  (reset),
            .inc    (inc_vec[i]),
            .clr    (clr_vec[i]),
            .weight (weights[i*WEIGHT_W +: WEIGHT_W]),
            .cnt    (cnt_all[i]),
            .ovf    (ovf_all[i])
        );
    end

    // Response stays frozen in RESP until acked; capture happens in the same cycle as the clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            rd_data_q  <= '0;
            rd_ovf_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rd_if.rd_req) begin
                        idx_q   <= rd_if.rd_idx;
                        busy_q  <= 1'b1;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    rd_data_q  <= idx_ok ? cnt_all[idx_q] : '0;
                    rd_ovf_q   <= idx_ok ? ovf_all[idx_q] : 1'b0;
                    rd_valid_q <= 1'b1;
                    state_q    <= ST_RESP;
                end
                ST_RESP: begin
                    if (rd_if.rd_ack) begin
                        rd_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    rd_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_if.rd_valid = rd_valid_q;
    assign rd_if.rd_data  = rd_data_q;
    assign rd_if.rd_ovf   = rd_ovf_q;
    assign rd_if.busy     = busy_q;

endmodule
